fp_mul_pipe: RTL
================

Name: fp_mul_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point multiplier with valid/ready handshakes on both sides.
- Successor to the fixed single-precision unpacked multiplier. Takes packed operands of any exponent/mantissa width.
- Adds round-to-nearest-even, normalisation, special-value handling, exception flags and backpressure.
- Sits in the FP datapath next to the add/sub unit. Feeds result buffers or a downstream accumulator.

Parameters:
- EXP_W, 8, exponent field width (min 4).
- MAN_W, 23, stored fraction width, hidden bit excluded (min 4).
- W, 1+EXP_W+MAN_W, packed operand/result width. Derived; do not override.
- BIAS, 2**(EXP_W-1)-1, exponent bias. Derived.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- a  in  W  operand A, packed {sign, exp, frac}
- b  in  W  operand B, packed
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  W  packed product
- flags  out  4  {nv, ovf, unf, nx}: invalid, overflow, underflow, inexact

Behaviour:
- Reset: all stage valids cleared. out_valid=0, result=0, flags=0. in_ready=1 in the cycle after reset deasserts.
- Reset mid-operation discards all in-flight operations. No partial output appears.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - result and flags hold stable while out_valid && !out_ready.
- Pipeline: 3 stages (S1, S2, S3) with one global advance signal: adv = !out_valid || out_ready.
  - in_ready = adv, combinational from out_ready and the S3 valid.
  - A bubble in any stage never blocks an upstream stage if adv=1.
  - Latency: 3 cycles from input transfer to out_valid with out_ready held high.
  - Throughput: 1 per cycle.
  - Results leave in issue order.
- S1 (unpack/classify):
  - Classify each operand as ZERO, SUB, NORM, INF, QNAN or SNAN. Subnormal inputs are flushed to signed zero.
  - sign = sa ^ sb.
  - Biased exponent sum ea+eb-BIAS, computed as signed EXP_W+2 bits.
  - Significands get the hidden bit: MAN_W+1 bits.
- S2 (multiply): full (2*MAN_W+2)-bit product. Special-case result chosen and carried alongside.
- S3 (normalise/round/pack):
  - If product MSB=1: shift right by 1, exponent+1.
  - Guard, round and sticky bits taken from the discarded product bits.
  - RNE: increment if G && (R || S || LSB).
  - A rounding carry-out renormalises the mantissa and increments the exponent again.
  - nx=1 if any discarded bit is nonzero.
  - Final exponent >= 2**EXP_W-1: result = signed infinity, ovf=1, nx=1.
  - Final exponent <= 0: result = signed zero (flush-to-zero), unf=1, nx=1.
- Special cases (override arithmetic, nx=0):
  - Any NaN operand: canonical qNaN {0, all-ones, 1, zeros}. nv=1 only if an operand is SNAN (fraction MSB=0, fraction nonzero).
  - ZERO x INF: canonical qNaN, nv=1.
  - INF x finite-nonzero or INF x INF: signed infinity.
  - ZERO x finite: signed zero, including -0 when signs differ.
- Flags are per-result and travel with their result. They are not sticky.

Decomposition:
- Package fp_mul_pkg:
  - fp_class_t enum {ZERO, SUB, NORM, INF, QNAN, SNAN}.
  - Flag bit indices FLAG_NV=3, FLAG_OVF=2, FLAG_UNF=1, FLAG_NX=0.
  - Function qnan(EXP_W, MAN_W) returning the canonical NaN.
- One sub-module fp_round_norm for the S3 logic (normalise, RNE, range check, pack), parametrised by EXP_W/MAN_W.
- S1/S2 stay inline.

Test Plan:
- 5.0 x -10.0 (a=32'h40A00000, b=32'hC1200000), out_ready=1 -> after 3 cycles result=32'hC2480000 (-50.0), flags=4'b0000.
- 32'h3F800001 x 32'h3F800001 -> result=32'h3F800002 (RNE), flags=4'b0001. 32'h3F800000 x 32'h3F800000 -> 32'h3F800000, flags=0.
- 32'h7F7FFFFF x 32'h40000000 -> 32'h7F800000, flags=4'b0101. 32'h00800000 x 32'h00800000 -> 32'h00000000, flags=4'b0011.
- 32'h00000000 x 32'h7F800000 -> 32'h7FC00000, flags=4'b1000. 32'h7FA00000 x 32'h3F800000 -> 32'h7FC00000, nv=1. 32'h80000000 x 32'h3F800000 -> 32'h80000000, flags=0.
- Backpressure: out_ready=0 while 5 back-to-back inputs offered.
  - in_ready drops after 3 are accepted.
  - result stays stable.
  - Release out_ready -> all 5 results appear in order with no loss or duplication.
- Reset asserted for 1 cycle with 2 ops in flight -> out_valid=0 the next cycle. Those ops never appear. A new op issued afterwards yields the correct result after 3 cycles.
- Parametrised build EXP_W=5, MAN_W=10 (half precision): 16'h3C00 x 16'hC000 -> 16'hC000; 16'h7BFF x 16'h4000 -> 16'h7C00 with ovf=1.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: operand classes, flag bit positions and canonical quiet-NaN builder for fp_mul_pipe
package fp_mul_pkg;
  typedef enum logic [2:0] {ZERO, SUB, NORM, INF, QNAN, SNAN} fp_class_t;
  localparam int FLAG_NV  = 3;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_NX  = 0;
  function automatic logic [127:0] qnan(input int exp_w, input int man_w);
    logic [127:0] one;
    one = 128'd1;
    return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
  endfunction
endpackage

// File: rtl/fp_round_norm.sv
// fp_round_norm: normalises a significand product, rounds to nearest even, range-checks and packs the result
module fp_round_norm
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                        sign,
  input  logic signed [EXP_W+1:0]     exp,
  input  logic        [2*MAN_W+1:0]   prod,
  output logic        [EXP_W+MAN_W:0] res,
  output logic        [3:0]           flags
);
  localparam int EW2 = EXP_W + 2;
  localparam int PW  = 2 * MAN_W + 2;
  localparam logic signed [EW2-1:0] EMAX = EW2'((1 << EXP_W) - 1);
  logic msb, g, r, s, inc, nx, ovf, unf;
  logic [PW-1:0] norm;
  logic [MAN_W:0] m;
  logic [MAN_W+1:0] sum;
  logic signed [EW2-1:0] e1, e2;
  logic [MAN_W-1:0] frac;
  always_comb begin
    msb = prod[PW-1];
    norm = msb ? prod : prod << 1;
    e1 = exp + EW2'(msb);
    m = norm[PW-1 -: MAN_W+1];
    g = norm[PW-MAN_W-2];
    r = norm[PW-MAN_W-3];
    s = |norm[PW-MAN_W-4:0];
    inc = g & (r | s | m[0]);
    sum = {1'b0, m} + (MAN_W+2)'(inc);
    e2 = e1 + EW2'(sum[MAN_W+1]);
    frac = sum[MAN_W+1] ? sum[MAN_W:1] : sum[MAN_W-1:0];
    nx = g | r | s;
    ovf = e2 >= EMAX;
    unf = !ovf && (e2[EW2-1] || e2 == '0);
    res = ovf ? {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
          unf ? {sign, {(EXP_W+MAN_W){1'b0}}} :
                {sign, e2[EXP_W-1:0], frac};
    flags = '0;
    flags[FLAG_OVF] = ovf;
    flags[FLAG_UNF] = unf;
    flags[FLAG_NX] = nx | ovf | unf;
  end
endmodule

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage pipelined IEEE-754 multiplier with RNE rounding, flush-to-zero and valid/ready flow control
module fp_mul_pipe
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam int EW2  = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam logic [127:0] QN_WIDE = qnan(EXP_W, MAN_W);
  localparam logic [W-1:0] QN = QN_WIDE[W-1:0];
  function automatic fp_class_t classify(input logic [W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e = x[W-2:MAN_W];
    f = x[MAN_W-1:0];
    return (e == '0) ? ((f == '0) ? ZERO : SUB) :
           (&e) ? ((f == '0) ? INF : (f[MAN_W-1] ? QNAN : SNAN)) : NORM;
  endfunction
  logic adv, s1_v, s1_sign, s2_v, s2_sign, s2_spec, s2_spec_nv, s3_v;
  logic nan, zero, inf, spec, spec_nv;
  logic signed [EW2-1:0] s1_exp, s2_exp;
  logic [MAN_W:0] s1_ma, s1_mb;
  fp_class_t s1_ca, s1_cb;
  logic [PW-1:0] s2_prod;
  logic [W-1:0] spec_res, s2_spec_res, rn_res;
  logic [3:0] rn_flags;
  assign adv = !s3_v || out_ready;
  assign in_ready = adv;
  assign out_valid = s3_v;
  always_comb begin
    nan = s1_ca inside {QNAN, SNAN} || s1_cb inside {QNAN, SNAN};
    zero = s1_ca inside {ZERO, SUB} || s1_cb inside {ZERO, SUB};
    inf = s1_ca == INF || s1_cb == INF;
    spec = nan || zero || inf;
    spec_nv = s1_ca == SNAN || s1_cb == SNAN || (!nan && inf && zero);
    spec_res = (nan || (inf && zero)) ? QN :
               inf ? {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {s1_sign, {(W-1){1'b0}}};
  end
  fp_round_norm #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_norm (
    .sign(s2_sign),
    .exp(s2_exp),
    .prod(s2_prod),
    .res(rn_res),
    .flags(rn_flags)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
      result <= '0;
      flags <= '0;
    end else if (adv) begin
      s1_v <= in_valid;
      s1_sign <= a[W-1] ^ b[W-1];
      s1_exp <= EW2'(a[W-2:MAN_W]) + EW2'(b[W-2:MAN_W]) - EW2'(BIAS);
      s1_ma <= {1'b1, a[MAN_W-1:0]};
      s1_mb <= {1'b1, b[MAN_W-1:0]};
      s1_ca <= classify(a);
      s1_cb <= classify(b);
      s2_v <= s1_v;
      s2_sign <= s1_sign;
      s2_exp <= s1_exp;
      s2_prod <= PW'(s1_ma) * PW'(s1_mb);
      s2_spec <= spec;
      s2_spec_res <= spec_res;
      s2_spec_nv <= spec_nv;
      s3_v <= s2_v;
      result <= s2_spec ? s2_spec_res : rn_res;
      flags <= s2_spec ? {s2_spec_nv, 3'b000} : rn_flags;
    end
  end
endmodule
